// File: rtl/la_stream_pkg.sv
// Shared encodings and defaults for the LA loopback stream checker.
// Optional capture of the first bad word is enabled by LA_STREAM_CAPTURE_EN.
package la_stream_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_PASS = 2'b10;
    localparam logic [1:0] ST_FAIL = 2'b11;

    localparam logic [1:0] FC_MISMATCH = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    localparam logic [31:0] DEF_TAP_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_PASS = ST_PASS,
        S_FAIL = ST_FAIL
    } state_t;

    function automatic logic [15:0] fail_bits(
        input logic [1:0]  code,
        input logic [2:0]  idx,
        input logic [10:0] beat
    );
        return {code, idx, beat};
    endfunction

endpackage

// File: rtl/la_lfsr_ch.sv
// Per-channel Fibonacci LFSR: seed load with zero fix-up, advance on match.
// Channel index is folded into the seed so channels run distinct sequences.
module la_lfsr_ch
    import la_stream_pkg::*;
#(
    parameter int          CH_W     = 32,
    parameter logic [31:0] TAP_MASK = DEF_TAP_MASK,
    parameter int          CH_IDX   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            adv,
    input  logic [CH_W-1:0] seed,
    output logic [CH_W-1:0] value
);

    localparam logic [CH_W-1:0] TAPS = TAP_MASK[CH_W-1:0];
    localparam logic [CH_W-1:0] KOFS = CH_W'(CH_IDX);

    logic [CH_W-1:0] seed_k;
    logic            fb;

    assign seed_k = seed ^ KOFS;
    assign fb     = ^(value & TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            // an all-zero state would lock the LFSR
            value <= (seed_k == '0) ? CH_W'(1) : seed_k;
        end else if (adv) begin
            value <= {value[CH_W-2:0], fb};
        end
    end

endmodule

// File: rtl/la_stream_checker.sv
// Multi-channel LA loopback checker reporting status/checkbits on user GPIO.
// Define LA_STREAM_CAPTURE_EN to add capt_o (first mismatching word).
module la_stream_checker
    import la_stream_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CH_W        = 32,
    parameter logic [31:0] TAP_MASK    = DEF_TAP_MASK,
    parameter int          TIMEOUT_CYC = 200000,
    parameter int          CNT_W       = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [NUM_CH-1:0]      ch_en_i,
    input  logic [CH_W-1:0]        seed_i,
    input  logic [CNT_W-1:0]       beats_i,
    input  logic                   la_strobe_i,
    input  logic [NUM_CH*CH_W-1:0] la_data_i,
    output logic [1:0]             status_o,
    output logic [15:0]            checkbits_o,
    output logic [CH_W-1:0]        expect_o,
    output logic [17:0]            io_oeb_o
`ifdef LA_STREAM_CAPTURE_EN
    ,
    output logic [CH_W-1:0]        capt_o
`endif
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);

    state_t state, state_nxt;

    logic                  strobe_q;
    logic                  beat_evt;
    logic [NUM_CH-1:0]     en_q;
    logic [CNT_W-1:0]      target_q;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [WD_W-1:0]       wdog;
    logic [1:0]            code_q;
    logic [2:0]            idx_q;
    logic [15:0]           cnt16;
    logic [CH_W-1:0]       lfsr [NUM_CH];
    logic [NUM_CH-1:0]     mis;
    logic [2:0]            mis_idx;
    logic                  last_beat;
    logic                  wd_hit;
    logic                  ld;
    logic                  adv;
    logic                  do_mis;
    logic                  do_to;

    assign beat_evt  = la_strobe_i ^ strobe_q;
    assign cnt_nxt   = count + CNT_W'(1);
    assign last_beat = (cnt_nxt == target_q);
    assign wd_hit    = (wdog == WD_W'(TIMEOUT_CYC - 1));

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        la_lfsr_ch #(
            .CH_W     (CH_W),
            .TAP_MASK (TAP_MASK),
            .CH_IDX   (k)
        ) u_lfsr (
            .clk   (wb_clk_i),
            .rst   (wb_rst_i),
            .load  (ld),
            .adv   (adv),
            .seed  (seed_i),
            .value (lfsr[k])
        );
    end

    always_comb begin
        mis     = '0;
        mis_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            mis[k] = en_q[k] && (la_data_i[k*CH_W +: CH_W] != lfsr[k]);
        end
        // walk downwards so the lowest failing channel wins
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mis[k]) begin
                mis_idx = 3'(k);
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        adv       = 1'b0;
        do_mis    = 1'b0;
        do_to     = 1'b0;
        if (abort_i) begin
            state_nxt = S_IDLE;
        end else if (start_i) begin
            state_nxt = S_RUN;
            ld        = 1'b1;
        end else if (state == S_RUN) begin
            if (beat_evt) begin
                if (|mis) begin
                    state_nxt = S_FAIL;
                    do_mis    = 1'b1;
                end else begin
                    adv = 1'b1;
                    if (last_beat) begin
                        state_nxt = S_PASS;
                    end
                end
            end else if (wd_hit) begin
                state_nxt = S_FAIL;
                do_to     = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            strobe_q <= 1'b0;
            en_q     <= '0;
            target_q <= '0;
            count    <= '0;
            wdog     <= '0;
            code_q   <= '0;
            idx_q    <= '0;
        end else begin
            strobe_q <= la_strobe_i;
            if (ld) begin
                en_q     <= ch_en_i;
                target_q <= (beats_i == '0) ? CNT_W'(1) : beats_i;
                count    <= '0;
                wdog     <= '0;
                code_q   <= '0;
                idx_q    <= '0;
            end else if (state == S_RUN && !abort_i) begin
                if (beat_evt) begin
                    wdog <= '0;
                end else if (!wd_hit) begin
                    wdog <= wdog + WD_W'(1);
                end
                if (adv) begin
                    count <= cnt_nxt;
                end
                if (do_mis) begin
                    code_q <= FC_MISMATCH;
                    idx_q  <= mis_idx;
                end else if (do_to) begin
                    code_q <= FC_TIMEOUT;
                    idx_q  <= '0;
                end
            end
        end
    end

`ifdef LA_STREAM_CAPTURE_EN
    logic [CH_W-1:0] mis_word;
    logic [CH_W-1:0] capt_q;

    always_comb begin
        mis_word = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mis[k]) begin
                mis_word = la_data_i[k*CH_W +: CH_W];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            capt_q <= '0;
        end else if (ld) begin
            capt_q <= '0;
        end else if (do_mis) begin
            capt_q <= mis_word;
        end
    end

    assign capt_o = capt_q;
`endif

    assign cnt16    = 16'(count);
    assign status_o = state;
    assign expect_o = lfsr[0];
    assign io_oeb_o = '0;

    always_comb begin
        checkbits_o = cnt16;
        if (state == S_FAIL) begin
            checkbits_o = fail_bits(code_q, idx_q, cnt16[10:0]);
        end
    end

endmodule

// File: tb/tb_la_stream_checker.sv
// Self-checking bench for la_stream_checker: vector table plus corner sequences.
// Expected words come from an independent LFSR model kept by the bench.
module tb_la_stream_checker;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 32;
    localparam int CNT_W  = 16;
    localparam int TO_CYC = 100;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic                   abort;
    logic [NUM_CH-1:0]      ch_en;
    logic [CH_W-1:0]        seed;
    logic [CNT_W-1:0]       beats;
    logic                   strobe;
    logic [NUM_CH*CH_W-1:0] data;
    logic [1:0]             status_o;
    logic [15:0]            checkbits_o;
    logic [CH_W-1:0]        expect_o;
    logic [17:0]            io_oeb_o;
`ifdef LA_STREAM_CAPTURE_EN
    logic [CH_W-1:0]        capt_o;
`endif

    la_stream_checker #(
        .NUM_CH      (NUM_CH),
        .CH_W        (CH_W),
        .TAP_MASK    (32'h8020_0003),
        .TIMEOUT_CYC (TO_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start_i     (start),
        .abort_i     (abort),
        .ch_en_i     (ch_en),
        .seed_i      (seed),
        .beats_i     (beats),
        .la_strobe_i (strobe),
        .la_data_i   (data),
        .status_o    (status_o),
        .checkbits_o (checkbits_o),
        .expect_o    (expect_o),
        .io_oeb_o    (io_oeb_o)
`ifdef LA_STREAM_CAPTURE_EN
        ,
        .capt_o      (capt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] seed;
        logic [3:0]  en;
        logic [15:0] beats;
        int          bad_ch;
        int          bad_beat;
        logic [31:0] bad_val;
        logic [1:0]  est;
        logic [15:0] ecb;
    } vec_t;

    typedef struct {
        logic [1:0]  st;
        logic [15:0] cb;
    } exp_t;

    vec_t        vecs[8];
    exp_t        sbq[$];
    logic [31:0] mdl[NUM_CH];
    int          n_chk;
    int          n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    task automatic model_seed(input logic [31:0] s);
        for (int k = 0; k < NUM_CH; k++) begin
            mdl[k] = s ^ 32'(k);
            if (mdl[k] == 32'h0) mdl[k] = 32'h1;
        end
    endtask

    task automatic model_adv();
        for (int k = 0; k < NUM_CH; k++) mdl[k] = nxt(mdl[k]);
    endtask

    function automatic logic [NUM_CH*CH_W-1:0] good_data();
        logic [NUM_CH*CH_W-1:0] d;
        for (int k = 0; k < NUM_CH; k++) d[k*CH_W +: CH_W] = mdl[k];
        return d;
    endfunction

    task automatic do_start(input logic [31:0] s, input logic [3:0] en, input logic [15:0] nb);
        @(negedge clk);
        seed  = s;
        ch_en = en;
        beats = nb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_seed(s);
    endtask

    task automatic drive_beat(input logic [NUM_CH*CH_W-1:0] d, input exp_t e);
        exp_t got;
        data   = d;
        strobe = ~strobe;
        sbq.push_back(e);
        @(negedge clk);
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'h1, 32'h0);
        end else begin
            got = sbq.pop_front();
            chk("beat_status", 32'(status_o), 32'(got.st));
            chk("beat_checkbits", 32'(checkbits_o), 32'(got.cb));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [NUM_CH*CH_W-1:0] d;
        logic [15:0]            tgt;
        logic [1:0]             st0;
        logic [15:0]            cb0;
        exp_t                   e;
        int                     fk;
        int                     b;
        bit                     done;

        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        ch_en  = '0;
        seed   = '0;
        beats  = '0;
        strobe = 1'b0;
        data   = '0;

        vecs[0] = '{32'h10, 4'hF, 16'd8, -1, -1, 32'h0, 2'b10, 16'h0008};
        vecs[1] = '{32'h10, 4'hF, 16'd8, 2, 5, 32'hDEAD_BEEF, 2'b11, 16'h5005};
        vecs[2] = '{32'h0, 4'hF, 16'd2, -1, -1, 32'h0, 2'b10, 16'h0002};
        vecs[3] = '{32'h0, 4'h1, 16'd4, 0, 0, 32'h0, 2'b11, 16'h4000};
        vecs[4] = '{32'h1234, 4'h0, 16'd3, 1, 1, 32'hFFFF_FFFF, 2'b10, 16'h0003};
        vecs[5] = '{32'hA5A5_0003, 4'hA, 16'd0, -1, -1, 32'h0, 2'b10, 16'h0001};
        vecs[6] = '{32'h3, 4'h8, 16'd5, 3, 3, 32'hDEAD_BEEF, 2'b11, 16'h5803};
        vecs[7] = '{32'h55, 4'h5, 16'd4, 1, 2, 32'h1234_5678, 2'b10, 16'h0004};

        repeat (3) @(negedge clk);
        chk("rst_status", 32'(status_o), 32'h0);
        chk("rst_checkbits", 32'(checkbits_o), 32'h0);
        chk("rst_expect", expect_o, 32'h0);
        chk("rst_oeb", 32'(io_oeb_o), 32'h0);
        rst = 1'b0;

        // toggles in IDLE must be ignored
        @(negedge clk);
        strobe = ~strobe;
        @(negedge clk);
        chk("idle_ignore", 32'(status_o), 32'h0);

        for (int v = 0; v < 8; v++) begin
            do_start(vecs[v].seed, vecs[v].en, vecs[v].beats);
            chk("start_status", 32'(status_o), 32'h1);
            chk("start_checkbits", 32'(checkbits_o), 32'h0);
            tgt  = (vecs[v].beats == 16'h0) ? 16'h1 : vecs[v].beats;
            done = 1'b0;
            b    = 0;
            while (!done && b < 64) begin
                chk("expect_word", expect_o, mdl[0]);
                d = good_data();
                if (b == vecs[v].bad_beat) d[vecs[v].bad_ch*CH_W +: CH_W] = vecs[v].bad_val;
                fk = -1;
                for (int k = NUM_CH - 1; k >= 0; k--) begin
                    if (vecs[v].en[k] && d[k*CH_W +: CH_W] != mdl[k]) fk = k;
                end
                if (fk >= 0) begin
                    e.st = 2'b11;
                    e.cb = {2'b01, 3'(fk), 11'(b)};
                    done = 1'b1;
                end else if (16'(b + 1) == tgt) begin
                    e.st = 2'b10;
                    e.cb = 16'(b + 1);
                    done = 1'b1;
                end else begin
                    e.st = 2'b01;
                    e.cb = 16'(b + 1);
                end
                drive_beat(d, e);
`ifdef LA_STREAM_CAPTURE_EN
                if (fk >= 0) chk("capt_word", capt_o, vecs[v].bad_val);
`endif
                model_adv();
                b++;
            end
            chk("final_status", 32'(status_o), 32'(vecs[v].est));
            chk("final_checkbits", 32'(checkbits_o), 32'(vecs[v].ecb));
            // PASS/FAIL are sticky against further strobes
            st0    = status_o;
            cb0    = checkbits_o;
            data   = {NUM_CH{32'hBAD0_BAD0}};
            strobe = ~strobe;
            repeat (2) @(negedge clk);
            chk("sticky_status", 32'(status_o), 32'(vecs[v].est));
            chk("sticky_checkbits", 32'(checkbits_o), 32'(cb0));
            chk("sticky_same", 32'(st0), 32'(status_o));
        end

        // watchdog expiry with no strobes
        do_start(32'h1, 4'hF, 16'd10);
        repeat (TO_CYC - 1) @(negedge clk);
        chk("to_still_run", 32'(status_o), 32'h1);
        @(negedge clk);
        chk("to_status", 32'(status_o), 32'h3);
        chk("to_checkbits", 32'(checkbits_o), 32'h8000);

        // a strobe just before expiry restarts the watchdog
        do_start(32'h1, 4'hF, 16'd10);
        repeat (TO_CYC - 2) @(negedge clk);
        e.st = 2'b01;
        e.cb = 16'h0001;
        drive_beat(good_data(), e);
        model_adv();
        repeat (TO_CYC - 1) @(negedge clk);
        chk("wd_reset_run", 32'(status_o), 32'h1);
        @(negedge clk);
        chk("wd_reset_status", 32'(status_o), 32'h3);
        chk("wd_reset_checkbits", 32'(checkbits_o), 32'h8001);

        // restart from FAIL reloads seeds and clears the counter
        do_start(32'h10, 4'hF, 16'd8);
        chk("restart_status", 32'(status_o), 32'h1);
        chk("restart_checkbits", 32'(checkbits_o), 32'h0);
        chk("restart_expect", expect_o, 32'h10);
        e.st = 2'b01;
        e.cb = 16'h0001;
        drive_beat(good_data(), e);
        model_adv();

        // abort wins over a simultaneous beat
        abort = 1'b1;
        data  = good_data();
        strobe = ~strobe;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_status", 32'(status_o), 32'h0);
        chk("abort_expect", expect_o, mdl[0]);

        // asynchronous reset in the middle of a run
        do_start(32'h10, 4'hF, 16'd8);
        e.st = 2'b01;
        e.cb = 16'h0001;
        drive_beat(good_data(), e);
        model_adv();
        e.cb = 16'h0002;
        drive_beat(good_data(), e);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_status", 32'(status_o), 32'h0);
        chk("arst_checkbits", 32'(checkbits_o), 32'h0);
        chk("arst_expect", expect_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/la_stream_checker.md
Name: la_stream_checker

Overview:
- Parametrised multi-channel logic-analyzer (LA) loopback checker inside the user project.
- Firmware streams pseudo-random words over the LA bus; the block regenerates the same per-channel LFSR sequence and compares each beat against it.
- It reports progress and pass/fail on the user GPIO pins: a 2-bit status on mprj_io[37:36] and 16 checkbits on mprj_io[31:16].
- Next generation of our single-word LA tests: N channels, configurable width and length, a watchdog timeout, and a failure code that identifies the channel and beat.

Parameters:
- NUM_CH, 4, number of LA channels checked in parallel (1..8).
- CH_W, 32, width of each channel word (8..32).
- TAP_MASK, 32'h8020_0003, Fibonacci LFSR tap mask; only bits [CH_W-1:0] are used.
- TIMEOUT_CYC, 200000, maximum cycles allowed between strobes while RUN, before a timeout failure.
- CNT_W, 16, width of the beat counter.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle pulse; starts a run
- abort_i  in  1  one-cycle pulse; returns to IDLE
- ch_en_i  in  NUM_CH  per-channel compare enable, sampled at start
- seed_i  in  CH_W  base seed, sampled at start
- beats_i  in  CNT_W  expected beat count, sampled at start; 0 means 1
- la_strobe_i  in  1  toggles once per new beat
- la_data_i  in  NUM_CH*CH_W  channel k occupies [k*CH_W +: CH_W]
- status_o  out  2  00 IDLE, 01 RUN, 10 PASS, 11 FAIL
- checkbits_o  out  16  progress or failure code
- expect_o  out  CH_W  channel-0 expected word, for firmware debug
- io_oeb_o  out  18  output-enable bars for mprj_io[37:36] and [31:16]

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, status_o=00, checkbits_o=0, expect_o=0, io_oeb_o=all 0 (driving).
  - All LFSRs 0, beat counter 0, watchdog 0, strobe history 0.
- Strobe detect: register la_strobe_i once; beat_evt = la_strobe_i XOR la_strobe_q. Detection latency is 1 cycle; la_data_i is sampled in the same cycle as beat_evt.
- LFSR per channel:
  - next = {x[CH_W-2:0], ^(x & TAP_MASK[CH_W-1:0])}.
  - Seed for channel k = seed_i XOR k. If that value is 0, load 1 instead (avoids LFSR lockup).
  - Beat 0 is compared against the seed itself.
- IDLE:
  - start_i: load seeds, latch ch_en_i and beats_i, clear counter and watchdog, sync la_strobe_q to la_strobe_i, go to RUN.
  - Strobe toggles are ignored in IDLE.
- RUN:
  - On beat_evt, compare every enabled channel's data with its LFSR value.
  - All enabled channels match: advance all LFSRs and increment the counter. If the counter reaches the latched beat count, go to PASS.
  - Any mismatch: go to FAIL with code 01. The lowest mismatching channel index is reported.
  - No beat_evt: increment the watchdog. When the watchdog reaches TIMEOUT_CYC-1, go to FAIL with code 10.
  - Watchdog is cleared on every beat_evt.
  - ch_en_i all zero at start: strobes still count, no comparisons are made, and the run ends in PASS.
- PASS/FAIL are sticky until start_i (begins a new run) or abort_i (returns to IDLE).
- Priority in one cycle: abort_i > start_i > beat_evt > timeout. start_i during RUN restarts the run cleanly.
- checkbits_o:
  - IDLE, RUN and PASS: counter[15:0] (zero-extended if CNT_W<16).
  - FAIL: {code[1:0], ch_idx[2:0], beat[10:0]}, where beat is the counter value at the failing beat.
- expect_o: channel-0 LFSR value; 0 in IDLE after reset.
- Counter wrap: with CNT_W=16 and beats_i=0xFFFF, PASS occurs at count 0xFFFF; the counter never wraps.
- Output latency: status_o and checkbits_o are registered and update 1 cycle after the deciding event.

Optional Feature:
- Macro LA_STREAM_CAPTURE_EN.
- Defined:
  - Adds output capt_o (CH_W), holding the first mismatching received word.
  - The word is captured on the transition to FAIL with code 01 and cleared on start_i and on reset.
- Undefined: no capt_o port and no capture register; all other behaviour is identical.

Decomposition:
- Package la_stream_pkg holds:
  - status encodings ST_IDLE/ST_RUN/ST_PASS/ST_FAIL;
  - fail codes FC_MISMATCH=2'b01, FC_TIMEOUT=2'b10;
  - the state typedef;
  - the default TAP_MASK constant.
- Sub-module la_lfsr_ch (one instance per channel, via generate) handles seed load, zero-seed fix-up and advance.

Test Plan:
- Reset check: assert wb_rst_i mid-RUN -> status_o=00, checkbits_o=0 immediately and asynchronously.
- Pass run: seed_i=0x10, ch_en_i=4'hF, beats_i=8. Firmware drives the correct LFSR words (ch0 0x10, ch1 0x11, ...) over 8 toggles -> status_o=10, checkbits_o=0x0008.
- Zero-seed handling: seed_i=0 -> ch0 beat0 expected 0x1, beat1 0x3. Driving these passes; driving 0x0 fails with checkbits_o=0x4000.
- Mismatch: seed_i=0x10, ch2 corrupted at beat 5 -> status_o=11, checkbits_o={01,010,00000000101}=0x5005. With the macro, capt_o equals the corrupted word.
- Timeout: TIMEOUT_CYC=100, start, no strobes -> FAIL after 100 cycles, checkbits_o=0x8000. A strobe at cycle 99 resets the watchdog.
- Collisions: abort_i with beat_evt in the same cycle -> IDLE. start_i in FAIL -> RUN, counter 0, seeds reloaded. ch_en_i=0 -> PASS despite garbage data.
